led_sequencer: RTL
==================

// Module: led_sequencer
// PURPOSE
//  Parametrised successor to the 3-bit button-driven LED colour cycler. Drives a WIDTH-bit colour
//  code that steps through [MIN_VAL..MAX_VAL] while a debounced button is held and freezes on release.
//  Adds up, down, ping-pong and hold modes, a step-rate prescaler, button sync/debounce, a wrap pulse
//  and recovery from illegal codes. Sits between the board push-button and the RGB LED driver.
// PARAMETERS
//  WIDTH      3  colour code width in bits
//  MIN_VAL    1  lowest legal code; also the reset value
//  MAX_VAL    6  highest legal code; requires MIN_VAL < MAX_VAL <= 2**WIDTH-1
//  DIV        1  steps occur every DIV clocks while held; DIV >= 1
//  DB_CYCLES  1  synced button must be stable this many clocks before it is accepted; >= 1
// PORTS
//  clk     in   1      system clock, rising edge
//  rst     in   1      synchronous, active-high reset
//  button  in   1      raw asynchronous push-button level
//  mode    in   2      00 up-wrap, 01 down-wrap, 10 ping-pong, 11 hold (no stepping)
//  colour  out  WIDTH  current colour code, registered
//  wrap    out  1      one-clock pulse, registered with colour, on a wrap or reversal step
//  active  out  1      debounced button level (btn_db)
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high. Reset (rst=1 at a rising edge) overrides
//    all logic: colour=MIN_VAL, wrap=0, active=0, dir=up, sync flops, debounce and prescaler counts = 0.
//  - Sync: button passes two flops, giving s. Debounce: if s==btn_db, db_cnt<=0. Otherwise, if
//    db_cnt==DB_CYCLES-1 then btn_db<=s and db_cnt<=0, else db_cnt++.
//  - Prescaler: while btn_db=0, pre_cnt<=0. While btn_db=1, step=1 when pre_cnt==DIV-1, and pre_cnt
//    wraps to 0; otherwise pre_cnt++.
//  - Latency: colour first changes at rising edge number 2+DB_CYCLES+DIV, counting the edge that first
//    samples button=1 as edge 1. After that it changes every DIV clocks.
//  - Release: stepping stops once btn_db falls, 2+DB_CYCLES edges after button is first sampled 0.
//    colour then holds indefinitely.
//  - Illegal code: colour<MIN_VAL or colour>MAX_VAL is checked every cycle, regardless of button or mode.
//    It forces colour=MIN_VAL and dir=up on the next edge with wrap=0. This takes priority over step.
//  - Step actions, applied only when step=1:
//      00: colour==MAX ? MIN with wrap=1 : colour+1
//      01: colour==MIN ? MAX with wrap=1 : colour-1
//      10, dir=up:   colour==MAX ? colour-1, dir<=down, wrap=1 : colour+1
//      10, dir=down: colour==MIN ? colour+1, dir<=up, wrap=1 : colour-1
//      11: colour unchanged, wrap=0, prescaler keeps running
//  - wrap is 0 on every cycle not listed above.
//  - mode is sampled each step; a change takes effect at the next step. dir persists across mode
//    changes and is used when ping-pong is re-entered.
//  - Arithmetic is WIDTH-bit unsigned. No overflow is possible because the range check precedes +/-1.
//  - Reset mid-sequence: colour returns to MIN_VAL. After rst deasserts, a held button needs the full
//    2+DB_CYCLES+DIV latency again, because btn_db was cleared.
// TESTING
//  1 rst=1 for 2 clks, button=0 -> colour=1, wrap=0, active=0; all stay put for 20 clks after release.
//  2 Defaults, mode=00, button held -> colour 1,2,3,4,5,6,1,2 on consecutive clks; first change at
//    edge 4; wrap=1 only on the 6->1 cycle.
//  3 mode=10, button held -> 1..6,5,4,3,2,1,2; wrap=1 on 6->5 and 1->2 only. Switch to 00 mid-descent
//    -> next step is +1.
//  4 mode=01 from reset, held -> 6 (wrap=1), 5, 4. Then mode=11 -> colour frozen, wrap=0, active=1.
//  5 DIV=4, DB_CYCLES=3: 2-clk button glitch -> active stays 0, colour stays 1. Hold -> first step at
//    edge 9, then every 4 clks. Release -> colour frozen after active falls.
//  6 Held at colour=4, rst pulse 1 clk -> colour=1 on next edge, first step 4 edges after rst falls.
//    force colour=7, release -> 1 on next edge, wrap=0.

Source files
------------

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : Button-driven colour code stepper with sync/debounce,
//               step prescaler, up/down/ping-pong/hold modes and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer #(
    parameter int WIDTH     = 3,
    parameter int MIN_VAL   = 1,
    parameter int MAX_VAL   = 6,
    parameter int DIV       = 1,
    parameter int DB_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] colour,
    output logic             wrap,
    output logic             active
);

    localparam int c_DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int c_PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(DIV - 1);
    localparam logic [WIDTH-1:0]   c_MIN      = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0]   c_MAX      = WIDTH'(MAX_VAL);

    localparam logic [1:0] c_MODE_UP   = 2'b00;
    localparam logic [1:0] c_MODE_DOWN = 2'b01;
    localparam logic [1:0] c_MODE_PING = 2'b10;
    localparam logic [1:0] c_MODE_HOLD = 2'b11;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               btn_db_q, btn_db_d;
    logic [c_DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [c_PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]   colour_q, colour_d;
    logic               wrap_q, wrap_d;
    dir_t               dir_q, dir_d;

    logic               w_step;
    logic               w_illegal;

    // Synchroniser, debounce and prescaler
    always_comb begin
        sync1_d   = button;
        sync2_d   = sync1_q;
        btn_db_d  = btn_db_q;
        db_cnt_d  = '0;
        pre_cnt_d = '0;
        w_step    = 1'b0;

        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == c_DB_LAST) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        if (btn_db_q) begin
            if (pre_cnt_q == c_PRE_LAST) begin
                w_step = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
        end
    end

    // Colour update; an out-of-range code is recovered before any step is taken
    always_comb begin
        colour_d  = colour_q;
        wrap_d    = 1'b0;
        dir_d     = dir_q;
        w_illegal = (colour_q < c_MIN) || (colour_q > c_MAX);

        if (w_illegal) begin
            colour_d = c_MIN;
            dir_d    = DIR_UP;
        end else if (w_step) begin
            case (mode)
                c_MODE_UP: begin
                    if (colour_q == c_MAX) begin
                        colour_d = c_MIN;
                        wrap_d   = 1'b1;
                    end else begin
                        colour_d = colour_q + 1'b1;
                    end
                end
                c_MODE_DOWN: begin
                    if (colour_q == c_MIN) begin
                        colour_d = c_MAX;
                        wrap_d   = 1'b1;
                    end else begin
                        colour_d = colour_q - 1'b1;
                    end
                end
                c_MODE_PING: begin
                    if (dir_q == DIR_UP) begin
                        if (colour_q == c_MAX) begin
                            colour_d = colour_q - 1'b1;
                            dir_d    = DIR_DOWN;
                            wrap_d   = 1'b1;
                        end else begin
                            colour_d = colour_q + 1'b1;
                        end
                    end else begin
                        if (colour_q == c_MIN) begin
                            colour_d = colour_q + 1'b1;
                            dir_d    = DIR_UP;
                            wrap_d   = 1'b1;
                        end else begin
                            colour_d = colour_q - 1'b1;
                        end
                    end
                end
                c_MODE_HOLD: begin
                    colour_d = colour_q;
                end
                default: begin
                    colour_d = colour_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            btn_db_q  <= 1'b0;
            db_cnt_q  <= '0;
            pre_cnt_q <= '0;
            colour_q  <= c_MIN;
            wrap_q    <= 1'b0;
            dir_q     <= DIR_UP;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            btn_db_q  <= btn_db_d;
            db_cnt_q  <= db_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            colour_q  <= colour_d;
            wrap_q    <= wrap_d;
            dir_q     <= dir_d;
        end
    end

    assign colour = colour_q;
    assign wrap   = wrap_q;
    assign active = btn_db_q;

endmodule
`default_nettype wire
